mem_access: RTL and testbench

Memory-access (MA) stage of the RISC-V core. It sits between the EX/MA pipeline register and the MA/WB register, and turns load/store ops into byte-serial transactions on the 8-bit memory-controller port. While a transaction runs it asks the upstream stages to stall. When the transaction finishes it presents the write-back triple (ma_we, ma_waddr, ma_wdata) to MA/WB. Non-memory instructions pass through in zero cycles.

---
 rtl/mem_access_pkg.sv | 48 ++++
 rtl/mem_access_ld_ext.sv | 22 ++
 rtl/mem_access.sv | 120 ++++++++++++
 tb/tb_mem_access.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, op codes, FSM states.
// No timing of its own; pure types and helpers.
package mem_access_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int MEM_OP_BUS   = 4;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] LB      = 4'd1;
  localparam logic [3:0] LH      = 4'd2;
  localparam logic [3:0] LW      = 4'd3;
  localparam logic [3:0] LBU     = 4'd4;
  localparam logic [3:0] LHU     = 4'd5;
  localparam logic [3:0] SB      = 4'd6;
  localparam logic [3:0] SH      = 4'd7;
  localparam logic [3:0] SW      = 4'd8;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_DONE   = 2'd2
  } ma_state_e;

  typedef struct packed {
    logic                    we;
    logic [REG_ADDR_BUS-1:0] waddr;
    logic [REG_BUS-1:0]      wdata;
  } wb_t;

  function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Byte count of an access; only meaningful for load/store ops.
  function automatic logic [2:0] op_nbytes(input logic [MEM_OP_BUS-1:0] op);
    logic [2:0] n;
    n = 3'd1;
    if ((op == LH) || (op == LHU) || (op == SH)) n = 3'd2;
    if ((op == LW) || (op == SW))                n = 3'd4;
    return n;
  endfunction

endpackage

// File: rtl/mem_access_ld_ext.sv
// Load-data extension: sign/zero-extends the assembled load buffer by op.
// Latency: combinational; no backpressure.
module ld_ext
  import mem_access_pkg::*;
(
  input  logic [MEM_OP_BUS-1:0] op,
  input  logic [REG_BUS-1:0]    ld_buf,
  output logic [REG_BUS-1:0]    ext
);

  always_comb begin
    ext = ld_buf;
    case (op)
      LB:      ext = {{24{ld_buf[7]}}, ld_buf[7:0]};
      LH:      ext = {{16{ld_buf[15]}}, ld_buf[15:0]};
      LBU:     ext = {24'd0, ld_buf[7:0]};
      LHU:     ext = {16'd0, ld_buf[15:0]};
      default: ext = ld_buf;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MA stage: serialises loads/stores onto the 8-bit memory port; ALU ops pass through.
// Latency: 0 cycles for non-memory ops, N+2 for N-byte accesses; holds on mem_ack wait and on rdy=0.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    ex_we,
  input  logic [REG_ADDR_BUS-1:0] ex_waddr,
  input  logic [REG_BUS-1:0]      ex_wdata,
  input  logic [MEM_OP_BUS-1:0]   ex_mem_op,
  input  logic [REG_BUS-1:0]      ex_mem_addr,
  input  logic [REG_BUS-1:0]      ex_mem_sdata,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [REG_BUS-1:0]      mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  input  logic                    mem_ack,
  output logic                    ma_we,
  output logic [REG_ADDR_BUS-1:0] ma_waddr,
  output logic [REG_BUS-1:0]      ma_wdata,
  output logic                    stall_req
);

  ma_state_e          state, state_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic [2:0]         nb, nb_nxt;
  logic [REG_BUS-1:0] ld_buf, buf_nxt;
  logic [REG_BUS-1:0] ext_dat;
  wb_t                wb;

  ld_ext u_ld_ext (
    .op     (ex_mem_op),
    .ld_buf (ld_buf),
    .ext    (ext_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MA_IDLE;
      cnt    <= 2'd0;
      nb     <= 3'd1;
      ld_buf <= '0;
    end else if (rdy) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      nb     <= nb_nxt;
      ld_buf <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nb_nxt    = nb;
    buf_nxt   = ld_buf;
    wb        = '0;
    stall_req = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      MA_IDLE: begin
        wb.we    = ex_we;
        wb.waddr = ex_waddr;
        wb.wdata = ex_wdata;
        if (is_load(ex_mem_op) || is_store(ex_mem_op)) begin
          wb.we     = 1'b0;
          stall_req = 1'b1;
          nb_nxt    = op_nbytes(ex_mem_op);
          cnt_nxt   = 2'd0;
          buf_nxt   = '0;
          state_nxt = MA_ACCESS;
        end
      end
      MA_ACCESS: begin
        // ex_* are frozen by stall_req, so address and data stay stable until ack.
        mem_req   = rdy;
        mem_wr    = is_store(ex_mem_op);
        mem_addr  = ex_mem_addr + {30'd0, cnt};
        mem_wdata = ex_mem_sdata[{cnt, 3'b000} +: 8];
        stall_req = 1'b1;
        wb.waddr  = ex_waddr;
        if (mem_ack) begin
          if (is_load(ex_mem_op)) buf_nxt[{cnt, 3'b000} +: 8] = mem_rdata;
          if ({1'b0, cnt} == nb - 3'd1) state_nxt = MA_DONE;
          else                          cnt_nxt   = cnt + 2'd1;
        end
      end
      MA_DONE: begin
        wb.waddr = ex_waddr;
        if (is_load(ex_mem_op)) begin
          wb.we    = ex_we;
          wb.wdata = ext_dat;
        end
        state_nxt = MA_IDLE;
      end
      default: state_nxt = MA_IDLE;
    endcase

    // Outputs are quiet for the whole reset window, not just after the next edge.
    if (!rst) begin
      wb        = '0;
      stall_req = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign ma_we    = wb.we;
  assign ma_waddr = wb.waddr;
  assign ma_wdata = wb.wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a cycle-stepped byte memory model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_mem_addr, ex_mem_sdata;
  logic [3:0]  ex_mem_op;
  logic        mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        ma_we;
  logic [4:0]  ma_waddr;
  logic [31:0] ma_wdata;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ma_we(ma_we), .ma_waddr(ma_waddr), .ma_wdata(ma_wdata), .stall_req(stall_req)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] bytes;     // loads: bytes returned by memory; stores: bytes expected on mem_wdata
    int          nbytes;
    int          nwait;
    logic        exp_wr;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A controller may only acknowledge a request that is actually being made.
  always @(negedge clk) begin
    #3;
    if (mem_ack) begin
      n_checks++;
      if (!mem_req) begin
        n_fail++;
        $display("FAIL ack_without_req: mem_req=%b while mem_ack=1", mem_req);
      end
    end
  end

  task automatic set_nop(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_mem_op    = MEM_NOP;
    ex_we        = we;
    ex_waddr     = wa;
    ex_wdata     = wd;
    ex_mem_addr  = 32'h0;
    ex_mem_sdata = 32'h0;
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input vec_t v);
    int stalls;
    stalls       = 0;
    ex_mem_op    = v.op;
    ex_mem_addr  = v.addr;
    ex_mem_sdata = v.sdata;
    ex_we        = v.we;
    ex_waddr     = v.waddr;
    ex_wdata     = 32'hDEADBEEF;
    @(negedge clk);
    chk({v.name, "/idle_stall"}, 32'(stall_req), 32'd1);
    chk({v.name, "/idle_we"},    32'(ma_we),     32'd0);
    chk({v.name, "/idle_req"},   32'(mem_req),   32'd0);
    if (stall_req) stalls++;
    for (int k = 0; k < v.nbytes; k++) begin
      for (int w = 0; w <= v.nwait; w++) begin
        @(negedge clk);
        chk({v.name, "/req"},  32'(mem_req), 32'd1);
        chk({v.name, "/addr"}, mem_addr,     v.addr + 32'(k));
        chk({v.name, "/wr"},   32'(mem_wr),  32'(v.exp_wr));
        if (v.exp_wr) chk({v.name, "/wdata"}, 32'(mem_wdata), 32'(v.bytes[8*k +: 8]));
        if (stall_req) stalls++;
        if (w == v.nwait) begin
          mem_ack   = 1'b1;
          mem_rdata = v.exp_wr ? 8'h00 : v.bytes[8*k +: 8];
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
      end
    end
    @(negedge clk);
    chk({v.name, "/done_stall"}, 32'(stall_req), 32'd0);
    chk({v.name, "/done_req"},   32'(mem_req),   32'd0);
    chk({v.name, "/done_we"},    32'(ma_we),     32'(v.exp_we));
    chk({v.name, "/done_waddr"}, 32'(ma_waddr),  32'(v.waddr));
    chk({v.name, "/done_wdata"}, ma_wdata,       v.exp_wdata);
    chk({v.name, "/stall_cycles"}, 32'(stalls), 32'(v.nbytes * (v.nwait + 1) + 1));
    @(posedge clk);
    #1;
    set_nop(1'b0, 5'd0, 32'h0);
  endtask

  // Single zero-wait byte; entered and left at posedge+1.
  task automatic ack_byte(input string name, input logic [31:0] exp_addr, input logic [7:0] d);
    @(negedge clk);
    chk({name, "/req"},  32'(mem_req), 32'd1);
    chk({name, "/addr"}, mem_addr,     exp_addr);
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"lw_unaligned", LW,  32'h0000_1001, 32'h0,         1'b1, 5'd7,  32'h12345678, 4, 0, 1'b0, 1'b1, 32'h12345678};
    vecs[1] = '{"lb_neg",       LB,  32'h0000_0010, 32'h0,         1'b1, 5'd3,  32'h00000080, 1, 0, 1'b0, 1'b1, 32'hFFFFFF80};
    vecs[2] = '{"lbu",          LBU, 32'h0000_0010, 32'h0,         1'b1, 5'd4,  32'h00000080, 1, 0, 1'b0, 1'b1, 32'h00000080};
    vecs[3] = '{"lh_neg",       LH,  32'h0000_0020, 32'h0,         1'b1, 5'd5,  32'h00009000, 2, 0, 1'b0, 1'b1, 32'hFFFF9000};
    vecs[4] = '{"lhu",          LHU, 32'h0000_0020, 32'h0,         1'b1, 5'd6,  32'h00009000, 2, 0, 1'b0, 1'b1, 32'h00009000};
    vecs[5] = '{"sh_wait",      SH,  32'h0000_2000, 32'hAABBCCDD,  1'b1, 5'd8,  32'h0000CCDD, 2, 1, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{"sw_unaligned", SW,  32'h0000_3003, 32'h11223344,  1'b0, 5'd0,  32'h11223344, 4, 0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{"sb",           SB,  32'h0000_0005, 32'hFFFFFF7E,  1'b1, 5'd1,  32'h0000007E, 1, 0, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{"lb_pos_wait",  LB,  32'h0000_0040, 32'h0,         1'b1, 5'd31, 32'h0000007F, 1, 2, 1'b0, 1'b1, 32'h0000007F};

    rst       = 1'b0;
    rdy       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    set_nop(1'b1, 5'd5, 32'h0000_1234);

    // Reset state: pass-through must be suppressed while rst is low.
    #12;
    chk("rst/ma_we",     32'(ma_we),     32'd0);
    chk("rst/ma_waddr",  32'(ma_waddr),  32'd0);
    chk("rst/ma_wdata",  ma_wdata,       32'd0);
    chk("rst/stall_req", 32'(stall_req), 32'd0);
    chk("rst/mem_req",   32'(mem_req),   32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU pass-through, same cycle.
    @(negedge clk);
    chk("nop/ma_we",     32'(ma_we),     32'd1);
    chk("nop/ma_waddr",  32'(ma_waddr),  32'd5);
    chk("nop/ma_wdata",  ma_wdata,       32'h0000_1234);
    chk("nop/stall_req", 32'(stall_req), 32'd0);
    chk("nop/mem_req",   32'(mem_req),   32'd0);
    @(posedge clk);
    #1;
    set_nop(1'b0, 5'd0, 32'h0);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Address wrap with a 3-cycle rdy freeze at byte 2.
    ex_mem_op   = LW;
    ex_mem_addr = 32'hFFFF_FFFE;
    ex_we       = 1'b1;
    ex_waddr    = 5'd12;
    ex_wdata    = 32'hDEADBEEF;
    @(negedge clk);
    chk("wrap/idle_stall", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1;
    ack_byte("wrap/b0", 32'hFFFF_FFFE, 8'hA1);
    ack_byte("wrap/b1", 32'hFFFF_FFFF, 8'hB2);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("freeze/mem_req",   32'(mem_req),   32'd0);
      chk("freeze/mem_addr",  mem_addr,       32'h0000_0000);
      chk("freeze/stall_req", 32'(stall_req), 32'd1);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    ack_byte("wrap/b2", 32'h0000_0000, 8'hC3);
    ack_byte("wrap/b3", 32'h0000_0001, 8'hD4);
    @(negedge clk);
    chk("wrap/done_we",    32'(ma_we),     32'd1);
    chk("wrap/done_wdata", ma_wdata,       32'hD4C3B2A1);
    chk("wrap/done_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    set_nop(1'b0, 5'd0, 32'h0);

    // Reset while ACCESS is at byte 2.
    ex_mem_op    = SW;
    ex_mem_addr  = 32'h0000_0100;
    ex_mem_sdata = 32'hA5A5_A5A5;
    ex_we        = 1'b1;
    ex_waddr     = 5'd9;
    ex_wdata     = 32'hDEADBEEF;
    @(negedge clk);
    @(posedge clk);
    #1;
    ack_byte("rstmid/b0", 32'h0000_0100, 8'h00);
    ack_byte("rstmid/b1", 32'h0000_0101, 8'h00);
    @(negedge clk);
    chk("rstmid/req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid/ma_we",     32'(ma_we),     32'd0);
    chk("rstmid/ma_waddr",  32'(ma_waddr),  32'd0);
    chk("rstmid/ma_wdata",  ma_wdata,       32'd0);
    chk("rstmid/stall_req", 32'(stall_req), 32'd0);
    chk("rstmid/mem_req",   32'(mem_req),   32'd0);
    chk("rstmid/mem_wr",    32'(mem_wr),    32'd0);
    chk("rstmid/mem_addr",  mem_addr,       32'd0);
    chk("rstmid/mem_wdata", 32'(mem_wdata), 32'd0);
    #4 rst = 1'b1;
    #1 set_nop(1'b1, 5'd9, 32'h0000_CAFE);
    #1;
    chk("rstmid/nop_we",    32'(ma_we),     32'd1);
    chk("rstmid/nop_waddr", 32'(ma_waddr),  32'd9);
    chk("rstmid/nop_wdata", ma_wdata,       32'h0000_CAFE);
    chk("rstmid/nop_stall", 32'(stall_req), 32'd0);
    chk("rstmid/nop_req",   32'(mem_req),   32'd0);
    @(posedge clk);
    #1;
    set_nop(1'b0, 5'd0, 32'h0);

    // The FSM must be fully usable after the abandoned access.
    run_op(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
